// File: rtl/int_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_controller_pkg
// Description : Register offsets, FSM encodings and STATUS bit layout shared
//               by the interrupt controller and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package int_controller_pkg;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_VBASE = 2'd2;
    localparam logic [1:0] REG_STAT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    localparam int STAT_INSVC_BIT = 15;
    localparam int STAT_INT_BIT   = 14;
    localparam int STAT_ID_MSB    = 2;

endpackage
`default_nettype wire

// File: rtl/int_controller_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Two-flop synchronizer for one request line followed by a
//               rising-edge detector on the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// Module      : int_controller
// Description : Fixed-priority interrupt controller with a 4-word register
//               window, pending latch and IDLE/REQ/SERVICE CPU handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module int_controller
    import int_controller_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [15:0] BASE      = 16'hFFF0,
    parameter logic [15:0] VEC_RESET = 16'h0100,
    parameter int          VEC_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             we,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             interrupt,
    output logic [15:0]      vector
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pend;
    logic [15:0]        r_vbase;
    logic [2:0]         r_id;
    logic [15:0]        r_vector;

    logic [N_SRC-1:0]   w_rise;
    logic [15:0]        w_off;
    logic               w_hit;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_vbase;
    logic [N_SRC-1:0]   w_req;
    logic [2:0]         w_win_id;
    logic [15:0]        w_win_vec;
    logic               w_latch;
    logic               w_act_pend;
    logic               w_act_mask;
    logic [N_SRC-1:0]   w_ack_clr;
    logic [N_SRC-1:0]   w_pend_nxt;

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            irq_sync_edge u_sync (
                .clk    (clk),
                .reset  (reset),
                .irq_in (irq_in[i]),
                .rise   (w_rise[i])
            );
        end
    endgenerate

    // Offset arithmetic keeps decode correct even for a BASE that is not 4-aligned.
    assign w_off      = addr - BASE;
    assign w_hit      = (w_off[15:2] == 14'd0);
    assign w_wr_mask  = we && w_hit && (w_off[1:0] == REG_MASK);
    assign w_wr_pend  = we && w_hit && (w_off[1:0] == REG_PEND);
    assign w_wr_vbase = we && w_hit && (w_off[1:0] == REG_VBASE);

    assign w_req = r_pend & r_mask;

    always_comb begin
        w_win_id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_id = 3'(i);
            end
        end
    end

    assign w_win_vec = r_vbase + (16'(w_win_id) << VEC_SHIFT);

    always_comb begin
        w_act_pend = 1'b0;
        w_act_mask = 1'b0;
        w_ack_clr  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_id == 3'(i)) begin
                w_act_pend   = r_pend[i];
                w_act_mask   = r_mask[i];
                w_ack_clr[i] = (r_state == S_REQ) && int_ack;
            end
        end
    end

    // A fresh edge on the same edge as a clear (ack or W1C) keeps the bit set.
    assign w_pend_nxt = (r_pend & ~(w_ack_clr | (w_wr_pend ? wdata[N_SRC-1:0] : '0))) | w_rise;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    w_state_nxt = S_SERV;
                end else if (!w_act_pend || !w_act_mask) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERV: begin
                if (int_ret) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask   <= '0;
            r_pend   <= '0;
            r_vbase  <= VEC_RESET;
            r_id     <= 3'd0;
            r_vector <= 16'h0000;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr_mask) begin
                r_mask <= wdata[N_SRC-1:0];
            end
            if (w_wr_vbase) begin
                r_vbase <= wdata;
            end
            if (w_latch) begin
                r_id     <= w_win_id;
                r_vector <= w_win_vec;
            end
        end
    end

    assign interrupt = (r_state == S_REQ);
    assign vector    = r_vector;

    // The id field reports zero when nothing is being requested or serviced.
    always_comb begin
        rdata = 16'h0000;
        if (w_hit) begin
            case (w_off[1:0])
                REG_MASK:  rdata[N_SRC-1:0] = r_mask;
                REG_PEND:  rdata[N_SRC-1:0] = r_pend;
                REG_VBASE: rdata            = r_vbase;
                REG_STAT: begin
                    rdata[STAT_INSVC_BIT]  = (r_state == S_SERV);
                    rdata[STAT_INT_BIT]    = (r_state == S_REQ);
                    rdata[STAT_ID_MSB:0]   = (r_state != S_IDLE) ? r_id : 3'd0;
                end
                default: rdata = 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_controller
// Description : Directed and randomized bench for int_controller against a
//               cycle-level behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_controller;

    localparam int          N_SRC     = 4;
    localparam logic [15:0] BASE      = 16'hFFF0;
    localparam logic [15:0] VEC_RESET = 16'h0100;
    localparam int          VEC_SHIFT = 2;
    localparam logic [15:0] A_MASK    = BASE;
    localparam logic [15:0] A_PEND    = BASE + 16'd1;
    localparam logic [15:0] A_VBASE   = BASE + 16'd2;
    localparam logic [15:0] A_STAT    = BASE + 16'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq_in = 4'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        int_ack = 1'b0;
    logic        int_ret = 1'b0;
    logic        interrupt;
    logic [15:0] vector;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register contents, request/service flags and the
    // last three sampled values of irq_in.
    logic [3:0]  m_mask, m_pend, h1, h2, h3;
    logic [15:0] m_vbase, m_vec;
    bit          m_req, m_srv;
    int          m_id;

    int_controller #(
        .N_SRC     (N_SRC),
        .BASE      (BASE),
        .VEC_RESET (VEC_RESET),
        .VEC_SHIFT (VEC_SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .int_ack   (int_ack),
        .int_ret   (int_ret),
        .interrupt (interrupt),
        .vector    (vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = 4'b0; m_pend = 4'b0; m_vbase = VEC_RESET; m_vec = 16'h0;
        m_req = 1'b0; m_srv = 1'b0; m_id = 0;
        h1 = 4'b0; h2 = 4'b0; h3 = 4'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        case (off)
            16'd0:   return {12'h0, m_mask};
            16'd1:   return {12'h0, m_pend};
            16'd2:   return m_vbase;
            16'd3:   return {m_srv, m_req, 11'h0, (m_req || m_srv) ? 3'(m_id) : 3'd0};
            default: return 16'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0]  rise, clr;
        logic [15:0] off;
        int          id;
        rise = h2 & ~h3;
        off  = addr - BASE;
        clr  = 4'b0;
        if (we && off == 16'd1) clr = wdata[3:0];
        if (!m_req && !m_srv) begin
            if ((m_pend & m_mask) != 4'b0) begin
                id = 0;
                while (!(m_pend[id] && m_mask[id])) id++;
                m_id  = id;
                m_vec = m_vbase + 16'(id * (1 << VEC_SHIFT));
                m_req = 1'b1;
            end
        end else if (m_req) begin
            if (int_ack) begin
                clr[m_id] = 1'b1;
                m_req = 1'b0;
                m_srv = 1'b1;
            end else if (!m_pend[m_id] || !m_mask[m_id]) begin
                m_req = 1'b0;
            end
        end else if (int_ret) begin
            m_srv = 1'b0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (we && off == 16'd0) m_mask = wdata[3:0];
        if (we && off == 16'd2) m_vbase = wdata;
        h3 = h2; h2 = h1; h1 = irq_in;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("interrupt", 32'(interrupt), 32'(m_req));
        check("vector", 32'(vector), 32'(m_vec));
        check("rdata", 32'(rdata), 32'(model_read(addr)));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_vector", 32'(vector), 32'd0);
        check("rst_rdata", 32'(rdata), 32'(model_read(addr)));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, 32'(rdata), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        read_chk("rst_mask", A_MASK, 16'h0000);
        read_chk("rst_pend", A_PEND, 16'h0000);
        read_chk("rst_vbase", A_VBASE, 16'h0100);
        read_chk("rst_stat", A_STAT, 16'h0000);
        read_chk("unmapped_hi", BASE + 16'd4, 16'h0000);
        read_chk("unmapped_lo", 16'h0000, 16'h0000);
        check("rst_int", 32'(interrupt), 32'd0);

        // Single source, 3-edge latency to pending and one more to interrupt
        wr(A_MASK, 16'h0004);
        addr = A_PEND;
        irq_in = 4'b0100; cycle();
        irq_in = 4'b0000; cycle(); cycle();
        check("pend_lat", 32'(rdata), 32'h0004);
        check("int_before", 32'(interrupt), 32'd0);
        cycle();
        check("int_req", 32'(interrupt), 32'd1);
        check("vec_id2", 32'(vector), 32'h0108);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        check("int_after_ack", 32'(interrupt), 32'd0);
        check("pend_after_ack", 32'(rdata), 32'h0000);
        read_chk("stat_serv", A_STAT, 16'h8002);
        int_ret = 1'b1; cycle(); int_ret = 1'b0;
        check("stat_after_ret", 32'(rdata), 32'h0000);

        // Priority: id 1 before id 3, then a 2-edge gap after return
        wr(A_MASK, 16'h000F);
        irq_in = 4'b1010; cycle();
        irq_in = 4'b0000; cycle(); cycle(); cycle();
        check("prio_vec1", 32'(vector), 32'h0104);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        int_ret = 1'b1; cycle(); int_ret = 1'b0;
        check("gap_int", 32'(interrupt), 32'd0);
        cycle();
        check("prio_int3", 32'(interrupt), 32'd1);
        check("prio_vec3", 32'(vector), 32'h010C);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        int_ret = 1'b1; cycle(); int_ret = 1'b0;

        // Masked source, then enabling it
        wr(A_MASK, 16'h0000);
        addr = A_PEND;
        irq_in = 4'b0001; cycle();
        irq_in = 4'b0000; cycle(); cycle(); cycle(); cycle();
        check("pend_masked", 32'(rdata), 32'h0001);
        check("int_masked", 32'(interrupt), 32'd0);
        wr(A_MASK, 16'h0001);
        cycle();
        check("int_unmask", 32'(interrupt), 32'd1);
        check("vec_id0", 32'(vector), 32'h0100);

        // W1C of the active request withdraws it
        wr(A_PEND, 16'h0001);
        check("w1c_still_req", 32'(interrupt), 32'd1);
        cycle();
        check("w1c_drop", 32'(interrupt), 32'd0);

        // New edge on the ack edge keeps the bit pending
        irq_in = 4'b0001; cycle();
        irq_in = 4'b0000; cycle();
        irq_in = 4'b0001; cycle();
        irq_in = 4'b0000; cycle();
        check("coll_req", 32'(interrupt), 32'd1);
        addr = A_PEND;
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        check("coll_pend", 32'(rdata), 32'h0001);

        // Reset while in service with a pending bit
        async_reset();
        read_chk("post_rst_mask", A_MASK, 16'h0000);
        read_chk("post_rst_vbase", A_VBASE, 16'h0100);
        addr = A_STAT;
        int_ret = 1'b1; cycle(); int_ret = 1'b0;
        check("post_rst_stat", 32'(rdata), 32'h0000);
        check("post_rst_int", 32'(interrupt), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom);
            we      = ($urandom_range(0, 5) == 0);
            addr    = BASE + 16'($urandom_range(0, 5)) - 16'd1;
            wdata   = 16'($urandom);
            int_ack = interrupt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            int_ret = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller directly upstream of the 16-bit single-cycle CPU; drives the CPU's interrupt request line and supplies the handler vector.
- Collects N_SRC asynchronous peripheral request lines and latches them as pending.
- Arbitrates by fixed priority, with the lowest index winning.
- Handshakes with the control unit: the CPU acknowledges entry and signals return.
- Software configures mask, vector base and pending state through a small memory-mapped register window on the CPU data/address bus.

Parameters:
- N_SRC, 4: number of request sources, 1..8.
- BASE, 16'hFFF0: bus address of register 0. Registers occupy BASE..BASE+3.
- VEC_RESET, 16'h0100: reset value of VEC_BASE.
- VEC_SHIFT, 2: handler spacing; vector = VEC_BASE + (id << VEC_SHIFT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  N_SRC  asynchronous request lines, rising-edge triggered.
- we  in  1  bus write strobe, sampled on clk.
- addr  in  16  bus address.
- wdata  in  16  bus write data.
- rdata  out  16  bus read data, combinational from addr.
- int_ack  in  1  CPU has taken the interrupt (pushed PC, jumped to vector).
- int_ret  in  1  CPU executed return-from-interrupt.
- interrupt  out  1  request to CPU control unit.
- vector  out  16  handler address, valid while interrupt=1 and held through service.

Behaviour:
- Reset (async): mask=0, pending=0, VEC_BASE=VEC_RESET, sync/edge flops=0, state=IDLE, interrupt=0, vector=0, active id=0.
- Input path: per-bit 2-flop synchronizer plus previous-value flop. pending[i] sets on the edge where sync2[i]=1 and prev[i]=0. pending is visible 3 rising edges after irq_in[i] is first sampled high. A level held high sets pending only once.
- Register map (word addresses):
  - BASE+0 MASK: R/W, bits N_SRC-1:0, 1 = enabled.
  - BASE+1 PENDING: reads the pending bits; writing 1 to a bit clears it (W1C).
  - BASE+2 VEC_BASE: R/W, full 16 bits.
  - BASE+3 STATUS: RO. bit15 = in service, bit14 = interrupt, bits 2:0 = active id.
  - Unused bits read 0. Unmapped addresses read 16'h0000. Writes take effect on the clock edge.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if (pending & mask) != 0, latch id = lowest set index and vector = VEC_BASE + (id << VEC_SHIFT), 16-bit wrap. Go to REQ next edge.
  - REQ: interrupt=1. On int_ack: clear pending[id], interrupt=0 on the same edge, go to SERVICE. If pending[id] or mask[id] drops before ack (W1C or mask write), deassert and return to IDLE without an ack.
  - SERVICE: interrupt=0, no nesting; new requests only accumulate as pending. On int_ret, go to IDLE. Re-arbitration occurs on the following cycle, so the minimum gap from int_ret to the next interrupt is 2 edges.
- Ignored events: int_ack outside REQ; int_ret outside SERVICE.
- Simultaneous set and clear on the same bit, same edge: set wins. This covers a new edge arriving while an ack or W1C is clearing that bit.
- VEC_BASE written while in REQ/SERVICE: the latched vector is unchanged; the new base applies to the next arbitration.
- Reset mid-REQ or mid-SERVICE: immediate return to reset values; pending requests are lost.

Decomposition:
- Shared package/header holds:
  - register offsets REG_MASK=0, REG_PEND=1, REG_VBASE=2, REG_STAT=3;
  - FSM state encodings S_IDLE, S_REQ, S_SERV (2 bits);
  - STATUS bit positions.
- One sub-module, irq_sync_edge: per-source synchronizer plus rising-edge detector, instanced N_SRC times (or vectorised).
- Priority encoder, register file and FSM stay in int_controller.

Test Plan:
- Reset then read all registers → MASK=0, PEND=0, VBASE=16'h0100, STAT=0, interrupt=0.
- MASK=4'b0100; pulse irq_in[2] → PEND=4'b0100 after 3 edges; interrupt=1 and vector=16'h0108 one edge later. int_ack → interrupt=0, PEND=0, STAT bit15=1. int_ret → STAT=0.
- MASK=4'hF; raise irq_in[3] and irq_in[1] on the same cycle → vector=16'h0104 (id 1) first. After ack and ret, vector=16'h010C (id 3).
- Masked source: MASK=0, pulse irq_in[0] → PEND bit0=1, interrupt stays 0. Then write MASK=1 → interrupt=1 within 2 edges.
- In REQ, W1C write PEND=4'b0001 for the active id 0 → interrupt drops next edge and state returns to IDLE. Separately, new irq_in[0] edge coinciding with int_ack → pending[0] remains 1.
- Assert reset in SERVICE with pending bits set → all outputs and registers return to reset values asynchronously; int_ret afterwards has no effect.
